audio_volume_ramp: RTL
======================

AUDIO_VOLUME_RAMP -- requirements
Module: audio_volume_ramp

Interface
REQ-001 Parameter IN_POS, default 8'd2: cnt256_n value at which input samples, target_gain and mute are sampled.
REQ-002 Parameter STEP, default 8'd1: gain change per frame while ramping; legal range 1..255.
REQ-003 mclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cnt256_n  input  8  free-running frame position from the clock generator; one frame is 256 mclk cycles.
REQ-006 ch1_in  input  16  signed two's-complement channel 1 sample from the processing stage.
REQ-007 ch2_in  input  16  signed two's-complement channel 2 sample.
REQ-008 target_gain  input  8  unsigned Q1.7 gain; 128 = unity, 0 = silence, 255 = ~1.99.
REQ-009 mute  input  1  soft-mute request; forces the effective target to 0.
REQ-010 ch1_out  output  16  signed gained channel 1 sample, to the TDM output stage.
REQ-011 ch2_out  output  16  signed gained channel 2 sample.
REQ-012 ramp_busy  output  1  high while current gain differs from the effective target.

Function
REQ-013 Frame edge: the rising edge at which cnt256_n == IN_POS; all frame-rate actions occur only on this edge.
REQ-014 At the frame edge, ch1_in, ch2_in and the current gain register (pre-update value) shall be captured into pipeline stage 1.
REQ-015 Stage 2, next edge: 16x9 signed products, sample * {1'b0,gain}, 25-bit result.
REQ-016 Stage 3, edge at cnt256_n == IN_POS+2 (mod 256): arithmetic right shift by 7 (round toward -inf), then saturate to [-32768, 32767]; load ch1_out/ch2_out.
REQ-017 Outputs shall hold constant for all other cycles of the frame; latency from input capture to output is 2 mclk cycles.
REQ-018 Effective target = 0 if mute is 1, else target_gain; both are sampled only at the frame edge.
REQ-019 Gain update at the frame edge: if gain < target, gain = min(gain+STEP, target); if gain > target, gain = max(gain-STEP, target); else unchanged; no overshoot or 8-bit wrap is permitted.
REQ-020 State machine (updated at the frame edge from the post-update gain):
- MUTED: gain == 0 and target == 0.
- STEADY: gain == target != 0.
- RAMP: gain != target.
REQ-021 ramp_busy shall equal (state == RAMP), registered.
REQ-022 A target change during RAMP re-aims the ramp at the next frame edge, with no restart from 0.
REQ-023 If mute and a target_gain change arrive at the same frame edge, mute wins.
REQ-024 Deasserting mute while in MUTED or ramping down shall ramp up from the current gain.
REQ-025 If IN_POS+1 or IN_POS+2 exceeds 255, the stage positions wrap modulo 256, and behaviour is otherwise identical.
REQ-026 Channels share one gain value and are processed in lockstep; no cross-channel mixing.

Reset
REQ-027 While rst_n == 0, regardless of the clock:
- ch1_out = ch2_out = 16'h0000
- gain = 0, all pipeline registers = 0
- state = MUTED, ramp_busy = 0
REQ-028 Reset asserted mid-frame or mid-ramp clears immediately; after release the block waits for the next frame edge and ramps from gain 0 toward the target (soft start).

Verification
REQ-029 Reset release, target_gain=128, mute=0, STEP=1, ch1_in=16'h4000 -> gain reaches 128 after 128 frame edges; ramp_busy high throughout, low after; ch1_out then 16'h4000.
REQ-030 Gain 255 steady, ch1_in=32767, ch2_in=-32768 -> ch1_out=32767, ch2_out=-32768 (saturated); gain 128, ch1_in=-1 -> ch1_out=-1.
REQ-031 Steady at 128, assert mute with STEP=16 -> gain 112, 96, ... 0 over 8 frames; state MUTED; outputs 0 thereafter.
REQ-032 Mid-ramp at gain 60 (target 100), change target to 50 -> next frame gain 59, ramps down to 50, no overshoot; STEP=8 from 46 to 50 -> 50 exactly.
REQ-033 IN_POS=8'd254 -> inputs captured at cnt 254, outputs change only at cnt 0; ch*_in toggled at other positions has no effect.
REQ-034 Assert rst_n=0 at cnt 100 during a ramp -> outputs 0 and ramp_busy 0 asynchronously (before the next mclk edge); soft start restarts from 0.

Source files
------------

// File: rtl/audio_volume_ramp.sv
// Stereo soft-volume stage: a gain register steps by STEP once per frame toward the
// mute-aware target, and a three-stage pipeline applies it to both channels with 16-bit saturation.
module audio_volume_ramp #(
    parameter logic [7:0] IN_POS = 8'd2,
    parameter logic [7:0] STEP   = 8'd1
) (
    input  logic               mclk,
    input  logic               rst_n,
    input  logic        [7:0]  cnt256_n,
    input  logic signed [15:0] ch1_in,
    input  logic signed [15:0] ch2_in,
    input  logic        [7:0]  target_gain,
    input  logic               mute,
    output logic signed [15:0] ch1_out,
    output logic signed [15:0] ch2_out,
    output logic               ramp_busy,
    output logic        [1:0]  o_dbg_state
);
    typedef enum logic [1:0] {
        ST_MUTED  = 2'd0,
        ST_STEADY = 2'd1,
        ST_RAMP   = 2'd2
    } state_t;

    // Stage positions wrap naturally in 8-bit arithmetic.
    localparam logic [7:0] MUL_POS = IN_POS + 8'd1;
    localparam logic [7:0] OUT_POS = IN_POS + 8'd2;

    state_t             r_state;
    state_t             w_state_next;
    logic        [7:0]  r_gain;
    logic        [7:0]  w_gain_next;
    logic        [7:0]  w_target;
    logic               r_busy;
    logic signed [15:0] r_s1_ch1;
    logic signed [15:0] r_s1_ch2;
    logic        [7:0]  r_s1_gain;
    logic signed [24:0] r_p1;
    logic signed [24:0] r_p2;
    logic signed [24:0] w_gain_x;
    logic               w_frame;
    logic               w_mul;
    logic               w_out;

    assign w_frame     = (cnt256_n == IN_POS);
    assign w_mul       = (cnt256_n == MUL_POS);
    assign w_out       = (cnt256_n == OUT_POS);
    assign w_gain_x    = 25'($signed({1'b0, r_s1_gain}));
    assign ramp_busy   = r_busy;
    assign o_dbg_state = r_state;

    // Shift by 7 (floor), then clamp to the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [24:0] p);
        logic signed [24:0] s;
        s = p >>> 7;
        if (s > 25'sd32767) begin
            sat16 = 16'sh7fff;
        end else if (s < -25'sd32768) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = s[15:0];
        end
    endfunction

    always_comb begin
        w_target     = mute ? 8'd0 : target_gain;
        w_gain_next  = r_gain;
        w_state_next = r_state;
        if (r_gain < w_target) begin
            w_gain_next = ((w_target - r_gain) <= STEP) ? w_target : (r_gain + STEP);
        end else if (r_gain > w_target) begin
            w_gain_next = ((r_gain - w_target) <= STEP) ? w_target : (r_gain - STEP);
        end
        if (w_gain_next != w_target) begin
            w_state_next = ST_RAMP;
        end else if (w_gain_next == 8'd0) begin
            w_state_next = ST_MUTED;
        end else begin
            w_state_next = ST_STEADY;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_MUTED;
            r_gain  <= 8'd0;
            r_busy  <= 1'b0;
        end else if (w_frame) begin
            r_state <= w_state_next;
            r_gain  <= w_gain_next;
            r_busy  <= (w_state_next == ST_RAMP);
        end
    end

    // The pipeline captures the gain before this frame's update takes effect.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_ch1  <= '0;
            r_s1_ch2  <= '0;
            r_s1_gain <= '0;
            r_p1      <= '0;
            r_p2      <= '0;
            ch1_out   <= '0;
            ch2_out   <= '0;
        end else begin
            if (w_frame) begin
                r_s1_ch1  <= ch1_in;
                r_s1_ch2  <= ch2_in;
                r_s1_gain <= r_gain;
            end
            if (w_mul) begin
                r_p1 <= 25'(r_s1_ch1) * w_gain_x;
                r_p2 <= 25'(r_s1_ch2) * w_gain_x;
            end
            if (w_out) begin
                ch1_out <= sat16(r_p1);
                ch2_out <= sat16(r_p2);
            end
        end
    end

endmodule
